// File: rtl/diff_mask_pkg.sv
// rtl/diff_mask_pkg.sv - shared FSM type and constants for diff_mask_stream
package diff_mask_pkg;

  localparam int   PIX_W     = 8;
  localparam logic MODE_MASK = 1'b0;
  localparam logic MODE_ABS  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/diff_lane.sv
// rtl/diff_lane.sv - one pixel lane: registered absolute difference, then mask/raw result
module diff_lane
  import diff_mask_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             s1_en,
  input  logic             s2_en,
  input  logic [PIX_W-1:0] base_px,
  input  logic [PIX_W-1:0] img_px,
  input  logic [PIX_W-1:0] thr,
  input  logic             mode_abs,
  output logic [PIX_W-1:0] res,
  output logic             gt
);

  logic [PIX_W:0]   delta;
  logic [PIX_W-1:0] diff_d, diff_q;
  logic [PIX_W-1:0] res_d, res_q;

  always_comb begin
    // a borrow in the 9-bit subtraction means img < base; negate the low byte
    delta  = {1'b0, img_px} - {1'b0, base_px};
    diff_d = diff_q;
    if (s1_en) begin
      diff_d = delta[PIX_W] ? (~delta[PIX_W-1:0] + PIX_W'(1)) : delta[PIX_W-1:0];
    end
    gt    = diff_q > thr;
    res_d = res_q;
    if (s2_en) begin
      res_d = mode_abs ? diff_q : (gt ? {PIX_W{1'b1}} : {PIX_W{1'b0}});
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      diff_q <= '0;
      res_q  <= '0;
    end else begin
      diff_q <= diff_d;
      res_q  <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: rtl/diff_mask_stream.sv
// rtl/diff_mask_stream.sv - joins base/image FIFOs, two-stage diff/mask pipeline, frame FSM
// Optional foreground lane counter output fg_count when DIFF_MASK_STATS_EN is defined.
module diff_mask_stream
  import diff_mask_pkg::*;
#(
  parameter int WIDTH    = 720,
  parameter int HEIGHT   = 540,
  parameter int CHANNELS = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      base_empty,
  output logic                      base_rd_en,
  input  logic [PIX_W*CHANNELS-1:0] base_dout,
  input  logic                      img_empty,
  output logic                      img_rd_en,
  input  logic [PIX_W*CHANNELS-1:0] img_dout,
  input  logic                      out_full,
  output logic                      out_wr_en,
  output logic [PIX_W*CHANNELS-1:0] out_din,
  input  logic [7:0]                threshold,
  input  logic                      mode,
  output logic                      frame_done
`ifdef DIFF_MASK_STATS_EN
  ,
  output logic [31:0]               fg_count
`endif
);

  localparam int BEATS = WIDTH * HEIGHT / CHANNELS;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  state_t            state_d, state_q;
  logic [CW-1:0]     beat_d, beat_q;
  logic              s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic [7:0]        thr_d, thr_q;
  logic              mode_d, mode_q;
  logic              s1_adv, s2_adv, s2_en, pop, last_beat;
  logic [CHANNELS-1:0] gt_vec;

  always_comb begin
    s2_adv     = !s2_valid_q || !out_full;
    s1_adv     = !s1_valid_q || s2_adv;
    s2_en      = s2_adv && s1_valid_q;
    // gated by reset so no pop can be seen while the block is held in reset
    pop        = reset && !base_empty && !img_empty && s1_adv &&
                 (state_q == ST_IDLE || state_q == ST_RUN);
    last_beat  = beat_q == CW'(BEATS - 1);
    s1_valid_d = s1_adv ? pop : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    beat_d     = pop ? (last_beat ? '0 : beat_q + CW'(1)) : beat_q;
    thr_d      = thr_q;
    mode_d     = mode_q;
    if (pop && state_q == ST_IDLE) begin
      thr_d  = threshold;
      mode_d = mode;
    end
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pop) state_d = last_beat ? ST_DRAIN : ST_RUN;
      ST_RUN:   if (pop && last_beat) state_d = ST_DRAIN;
      ST_DRAIN: if (!s1_valid_q && !s2_valid_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      thr_q      <= '0;
      mode_q     <= MODE_MASK;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      thr_q      <= thr_d;
      mode_q     <= mode_d;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    diff_lane u_lane (
      .clock    (clock),
      .reset    (reset),
      .s1_en    (pop),
      .s2_en    (s2_en),
      .base_px  (base_dout[PIX_W*k +: PIX_W]),
      .img_px   (img_dout[PIX_W*k +: PIX_W]),
      .thr      (thr_q),
      .mode_abs (mode_q == MODE_ABS),
      .res      (out_din[PIX_W*k +: PIX_W]),
      .gt       (gt_vec[k])
    );
  end

  assign base_rd_en = pop;
  assign img_rd_en  = pop;
  assign out_wr_en  = s2_valid_q && !out_full;
  assign frame_done = state_q == ST_DONE;

`ifdef DIFF_MASK_STATS_EN
  logic [31:0] fg_d, fg_q, fg_add;

  always_comb begin
    fg_add = '0;
    for (int k = 0; k < CHANNELS; k++) fg_add = fg_add + {31'd0, gt_vec[k]};
    fg_d = fg_q;
    if (pop && state_q == ST_IDLE) fg_d = '0;
    else if (s2_en) fg_d = fg_q + fg_add;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) fg_q <= '0;
    else        fg_q <= fg_d;
  end

  assign fg_count = fg_q;
`else
  logic unused_gt;
  assign unused_gt = ^gt_vec;
`endif

endmodule

// File: tb/tb_diff_mask_stream.sv
// tb/tb_diff_mask_stream.sv - randomized self-checking bench with FIFO and result models
module tb_diff_mask_stream;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        out_full = 1'b0;
  logic [7:0]  threshold = '0;
  logic        mode = 1'b0;
  logic        base_empty1, img_empty1, base_rd_en1, img_rd_en1, out_wr_en1, frame_done1;
  logic [7:0]  base_dout1, img_dout1, out_din1;
  logic        base_empty4, img_empty4, base_rd_en4, img_rd_en4, out_wr_en4, frame_done4;
  logic [31:0] base_dout4, img_dout4, out_din4;
`ifdef DIFF_MASK_STATS_EN
  logic [31:0] fg_count1, fg_count4, fg1_seen, fg4_seen;
`endif

  int total = 0, bad = 0, cyc = 0;
  int pop1_cnt, done1_cnt, pop4_cnt, done4_cnt, exp_fg1, exp_fg4;
  int split_cnt = 0, bad_pop = 0;
  bit img_gap = 0;
  logic        fr_mode;
  logic [7:0]  fr_th;
  logic [7:0]  b1_q[$], i1_q[$], exp1_q[$], got1_q[$];
  logic [31:0] b4_q[$], i4_q[$], exp4_q[$], got4_q[$];
  int          pop1_cyc[$], push1_cyc[$];

  always #5 clock = ~clock;

  diff_mask_stream #(.WIDTH(4), .HEIGHT(2), .CHANNELS(1)) dut1 (
    .clock(clock), .reset(reset),
    .base_empty(base_empty1), .base_rd_en(base_rd_en1), .base_dout(base_dout1),
    .img_empty(img_empty1), .img_rd_en(img_rd_en1), .img_dout(img_dout1),
    .out_full(out_full), .out_wr_en(out_wr_en1), .out_din(out_din1),
    .threshold(threshold), .mode(mode), .frame_done(frame_done1)
`ifdef DIFF_MASK_STATS_EN
    , .fg_count(fg_count1)
`endif
  );

  diff_mask_stream #(.WIDTH(4), .HEIGHT(2), .CHANNELS(4)) dut4 (
    .clock(clock), .reset(reset),
    .base_empty(base_empty4), .base_rd_en(base_rd_en4), .base_dout(base_dout4),
    .img_empty(img_empty4), .img_rd_en(img_rd_en4), .img_dout(img_dout4),
    .out_full(out_full), .out_wr_en(out_wr_en4), .out_din(out_din4),
    .threshold(threshold), .mode(mode), .frame_done(frame_done4)
`ifdef DIFF_MASK_STATS_EN
    , .fg_count(fg_count4)
`endif
  );

  function automatic int absd(input logic [7:0] b, input logic [7:0] i);
    int d;
    d = int'(i) - int'(b);
    return (d < 0) ? -d : d;
  endfunction

  function automatic logic [7:0] ref_px(input logic [7:0] b, input logic [7:0] i,
                                        input logic [7:0] th, input logic m);
    int d;
    d = absd(b, i);
    if (m) return 8'(d);
    return (d > int'(th)) ? 8'hFF : 8'h00;
  endfunction

  function automatic void drive();
    base_empty1 = b1_q.size() == 0;
    base_dout1  = (b1_q.size() > 0) ? b1_q[0] : 8'h00;
    img_empty1  = (i1_q.size() == 0) || (img_gap && cyc[0]);
    img_dout1   = (i1_q.size() > 0) ? i1_q[0] : 8'h00;
    base_empty4 = b4_q.size() == 0;
    base_dout4  = (b4_q.size() > 0) ? b4_q[0] : 32'h0;
    img_empty4  = i4_q.size() == 0;
    img_dout4   = (i4_q.size() > 0) ? i4_q[0] : 32'h0;
  endfunction

  task automatic tick();
    logic p1, p4;
    @(negedge clock);
    p1 = base_rd_en1;
    p4 = base_rd_en4;
    if (base_rd_en1 !== img_rd_en1 || base_rd_en4 !== img_rd_en4) split_cnt++;
    if (p1 && (base_empty1 || img_empty1)) bad_pop++;
    if (p4 && (base_empty4 || img_empty4)) bad_pop++;
    if (p1) begin pop1_cnt++; pop1_cyc.push_back(cyc); end
    if (p4) pop4_cnt++;
    if (out_wr_en1) begin got1_q.push_back(out_din1); push1_cyc.push_back(cyc); end
    if (out_wr_en4) got4_q.push_back(out_din4);
    if (frame_done1) done1_cnt++;
    if (frame_done4) done4_cnt++;
`ifdef DIFF_MASK_STATS_EN
    if (frame_done1) fg1_seen = fg_count1;
    if (frame_done4) fg4_seen = fg_count4;
`endif
    @(posedge clock);
    #1;
    if (p1 && b1_q.size() > 0) begin void'(b1_q.pop_front()); void'(i1_q.pop_front()); end
    if (p4 && b4_q.size() > 0) begin void'(b4_q.pop_front()); void'(i4_q.pop_front()); end
    cyc++;
    drive();
  endtask

  task automatic start_frame1(input logic m, input logic [7:0] th,
                              input logic [7:0] pb0, input logic [7:0] pi0,
                              input logic [7:0] pb1, input logic [7:0] pi1);
    logic [7:0] b, i;
    mode = m; threshold = th; fr_mode = m; fr_th = th;
    got1_q.delete(); exp1_q.delete(); pop1_cyc.delete(); push1_cyc.delete();
    pop1_cnt = 0; done1_cnt = 0; exp_fg1 = 0;
    for (int k = 0; k < 8; k++) begin
      b = (k == 0) ? pb0 : (k == 1) ? pb1 : 8'($urandom);
      i = (k == 0) ? pi0 : (k == 1) ? pi1 : 8'($urandom);
      b1_q.push_back(b);
      i1_q.push_back(i);
      exp1_q.push_back(ref_px(b, i, th, m));
      if (absd(b, i) > int'(th)) exp_fg1++;
    end
    drive();
  endtask

  task automatic finish_frame1(input string name, input bit chk_lat);
    bit flipped = 0;
    int lat_bad = 0;
    for (int k = 0; k < 300 && done1_cnt == 0; k++) begin
      tick();
      // later changes to mode/threshold must not affect a running frame
      if (!flipped && pop1_cnt > 0) begin mode = ~fr_mode; threshold = ~fr_th; flipped = 1; end
    end
    total++;
    if (done1_cnt == 0) begin bad++; $display("FAIL %s_timeout got=no frame_done want=frame_done", name); end
    for (int k = 0; k < 3; k++) tick();
    total++;
    if (done1_cnt !== 1) begin bad++; $display("FAIL %s_done_pulses got=%0d want=1", name, done1_cnt); end
    total++;
    if (pop1_cnt !== 8) begin bad++; $display("FAIL %s_pops got=%0d want=8", name, pop1_cnt); end
    total++;
    if (got1_q.size() !== 8) begin bad++; $display("FAIL %s_pushes got=%0d want=8", name, got1_q.size()); end
    for (int k = 0; k < 8 && k < got1_q.size(); k++) begin
      total++;
      if (got1_q[k] !== exp1_q[k]) begin
        bad++; $display("FAIL %s_beat%0d got=%02h want=%02h", name, k, got1_q[k], exp1_q[k]);
      end
    end
    if (chk_lat) begin
      for (int k = 0; k < pop1_cyc.size() && k < push1_cyc.size(); k++)
        if (push1_cyc[k] - pop1_cyc[k] != 2) lat_bad++;
      total++;
      if (lat_bad !== 0) begin bad++; $display("FAIL %s_latency got=%0d off beats want=0", name, lat_bad); end
    end
`ifdef DIFF_MASK_STATS_EN
    total++;
    if (fg1_seen !== 32'(exp_fg1)) begin bad++; $display("FAIL %s_fg got=%0d want=%0d", name, fg1_seen, exp_fg1); end
`endif
  endtask

  task automatic test_reset();
    b1_q = '{8'd1, 8'd2}; i1_q = '{8'd9, 8'd9};
    b4_q = '{32'h1}; i4_q = '{32'h2};
    drive();
    tick(); tick();
    total++; if (base_rd_en1 !== 1'b0) begin bad++; $display("FAIL reset_base_rd_en got=%b want=0", base_rd_en1); end
    total++; if (img_rd_en1 !== 1'b0) begin bad++; $display("FAIL reset_img_rd_en got=%b want=0", img_rd_en1); end
    total++; if (out_wr_en1 !== 1'b0) begin bad++; $display("FAIL reset_out_wr_en got=%b want=0", out_wr_en1); end
    total++; if (out_din1 !== 8'h00) begin bad++; $display("FAIL reset_out_din got=%02h want=00", out_din1); end
    total++; if (frame_done1 !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done1); end
    total++; if (base_rd_en4 !== 1'b0) begin bad++; $display("FAIL reset_rd_en4 got=%b want=0", base_rd_en4); end
    total++; if (out_din4 !== 32'h0) begin bad++; $display("FAIL reset_out_din4 got=%08h want=0", out_din4); end
`ifdef DIFF_MASK_STATS_EN
    total++; if (fg_count1 !== 32'h0) begin bad++; $display("FAIL reset_fg got=%0d want=0", fg_count1); end
`endif
    b1_q.delete(); i1_q.delete(); b4_q.delete(); i4_q.delete();
    drive();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mask();
    start_frame1(1'b0, 8'd30, 8'd10, 8'd50, 8'd10, 8'd35);
    finish_frame1("mask", 1);
    if (got1_q.size() >= 2) begin
      total++; if (got1_q[0] !== 8'hFF) begin bad++; $display("FAIL mask_first got=%02h want=ff", got1_q[0]); end
      total++; if (got1_q[1] !== 8'h00) begin bad++; $display("FAIL mask_second got=%02h want=00", got1_q[1]); end
    end
  endtask

  task automatic test_abs();
    start_frame1(1'b1, 8'($urandom), 8'd200, 8'd20, 8'($urandom), 8'($urandom));
    finish_frame1("abs", 1);
    if (got1_q.size() >= 1) begin
      total++; if (got1_q[0] !== 8'd180) begin bad++; $display("FAIL abs_no_wrap got=%0d want=180", got1_q[0]); end
    end
  endtask

  task automatic test_stall();
    logic [7:0] hold;
    int p, n;
    bit moved = 0;
    start_frame1(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    for (int k = 0; k < 50 && pop1_cnt < 3; k++) tick();
    out_full = 1'b1;
    #1;
    hold = out_din1; p = pop1_cnt; n = got1_q.size();
    for (int k = 0; k < 5; k++) begin
      tick();
      if (out_din1 !== hold) moved = 1;
    end
    total++; if (pop1_cnt !== p) begin bad++; $display("FAIL stall_pops got=%0d want=%0d", pop1_cnt, p); end
    total++; if (got1_q.size() !== n) begin bad++; $display("FAIL stall_pushes got=%0d want=%0d", got1_q.size(), n); end
    total++; if (moved) begin bad++; $display("FAIL stall_out_din got=changed want=stable %02h", hold); end
    out_full = 1'b0;
    finish_frame1("stall", 0);
  endtask

  task automatic test_gaps();
    split_cnt = 0; bad_pop = 0; img_gap = 1;
    start_frame1(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    finish_frame1("gaps", 1);
    img_gap = 0;
    drive();
    total++; if (bad_pop !== 0) begin bad++; $display("FAIL gaps_pop_on_empty got=%0d want=0", bad_pop); end
    total++; if (split_cnt !== 0) begin bad++; $display("FAIL gaps_split_rd_en got=%0d want=0", split_cnt); end
  endtask

  task automatic test_wide();
    logic        m;
    logic [7:0]  th;
    logic [31:0] b, i, e;
    bit flipped = 0;
    m = 1'($urandom); th = 8'($urandom);
    mode = m; threshold = th;
    pop4_cnt = 0; done4_cnt = 0; exp_fg4 = 0; got4_q.delete(); exp4_q.delete();
    for (int w = 0; w < 2; w++) begin
      b = $urandom; i = $urandom;
      for (int k = 0; k < 4; k++) begin
        e[8*k +: 8] = ref_px(b[8*k +: 8], i[8*k +: 8], th, m);
        if (absd(b[8*k +: 8], i[8*k +: 8]) > int'(th)) exp_fg4++;
      end
      b4_q.push_back(b); i4_q.push_back(i); exp4_q.push_back(e);
    end
    drive();
    for (int k = 0; k < 100 && done4_cnt == 0; k++) begin
      tick();
      if (!flipped && pop4_cnt > 0) begin mode = ~m; threshold = ~th; flipped = 1; end
    end
    for (int k = 0; k < 3; k++) tick();
    total++; if (done4_cnt !== 1) begin bad++; $display("FAIL wide_done_pulses got=%0d want=1", done4_cnt); end
    total++; if (pop4_cnt !== 2) begin bad++; $display("FAIL wide_pops got=%0d want=2", pop4_cnt); end
    total++; if (got4_q.size() !== 2) begin bad++; $display("FAIL wide_pushes got=%0d want=2", got4_q.size()); end
    for (int k = 0; k < 2 && k < got4_q.size(); k++) begin
      total++;
      if (got4_q[k] !== exp4_q[k]) begin bad++; $display("FAIL wide_beat%0d got=%08h want=%08h", k, got4_q[k], exp4_q[k]); end
    end
    total++; if (frame_done4 !== 1'b0) begin bad++; $display("FAIL wide_done_after got=%b want=0", frame_done4); end
`ifdef DIFF_MASK_STATS_EN
    total++; if (fg4_seen !== 32'(exp_fg4)) begin bad++; $display("FAIL wide_fg got=%0d want=%0d", fg4_seen, exp_fg4); end
`endif
  endtask

  task automatic test_mid_reset();
    start_frame1(1'b0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd255);
    for (int k = 0; k < 50 && pop1_cnt < 3; k++) tick();
    reset = 1'b0;
    #1;
    total++; if (base_rd_en1 !== 1'b0) begin bad++; $display("FAIL midrst_rd_en got=%b want=0", base_rd_en1); end
    total++; if (out_wr_en1 !== 1'b0) begin bad++; $display("FAIL midrst_wr_en got=%b want=0", out_wr_en1); end
    total++; if (out_din1 !== 8'h00) begin bad++; $display("FAIL midrst_out_din got=%02h want=00", out_din1); end
    total++; if (frame_done1 !== 1'b0) begin bad++; $display("FAIL midrst_frame_done got=%b want=0", frame_done1); end
`ifdef DIFF_MASK_STATS_EN
    total++; if (fg_count1 !== 32'h0) begin bad++; $display("FAIL midrst_fg got=%0d want=0", fg_count1); end
`endif
    b1_q.delete(); i1_q.delete();
    drive();
    tick(); tick();
    reset = 1'b1;
    tick();
    start_frame1(1'b0, 8'($urandom_range(0, 100)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    finish_frame1("post_reset", 1);
  endtask

  initial begin
    drive();
    test_reset();
    test_mask();
    test_abs();
    test_stall();
    test_gaps();
    test_wide();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/diff_mask_stream.md
DIFF_MASK_STREAM -- requirements
Module: diff_mask_stream

Interface
REQ-001 Parameter WIDTH, default 720: frame width in pixels.
REQ-002 Parameter HEIGHT, default 540: frame height in pixels.
REQ-003 Parameter CHANNELS, default 1: 8-bit pixel lanes per beat; WIDTH*HEIGHT SHALL be divisible by CHANNELS.
REQ-004 Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- base_empty  in  1  base FIFO empty.
- base_rd_en  out  1  base FIFO pop.
- base_dout  in  8*CHANNELS  base pixels.
- img_empty  in  1  image FIFO empty.
- img_rd_en  out  1  image FIFO pop.
- img_dout  in  8*CHANNELS  image pixels.
- out_full  in  1  output FIFO full.
- out_wr_en  out  1  output FIFO push.
- out_din  out  8*CHANNELS  result pixels.
- threshold  in  8  mask threshold.
- mode  in  1  0 = binary mask, 1 = raw absolute difference.
- frame_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-005 Lane k occupies bits [8k+7:8k] of every data bus; lanes are independent.
REQ-006 Join: base_rd_en and img_rd_en SHALL be asserted together, only when both FIFOs are non-empty, the FSM is IDLE or RUN, and stage 1 can advance; they are never asserted separately.
REQ-007 Stage 1 SHALL register diff = |img - base| per lane in 8 bits, computed with a 9-bit intermediate; no wrap-around.
REQ-008 Stage 2 SHALL register the result per lane: mode 0 -> 8'hFF if diff > threshold, else 8'h00; mode 1 -> diff.
REQ-009 out_wr_en SHALL be asserted when stage 2 is valid and out_full is 0; latency from pop to push SHALL be 2 cycles with no stall.
REQ-010 Stall: when out_full=1 and stage 2 is valid, both stages SHALL hold and no pop SHALL occur; no beat is lost or duplicated.
REQ-011 threshold and mode SHALL be latched on the first pop of each frame and held constant for that frame.
REQ-012 A beat counter SHALL count pops from 0 to WIDTH*HEIGHT/CHANNELS-1 and wrap to 0 at frame end.
REQ-013 FSM states and transitions:
- IDLE -> RUN on the first pop.
- RUN -> DRAIN on the pop of the last beat.
- DRAIN -> DONE when both stages are empty.
- DONE -> IDLE after one cycle.
REQ-014 frame_done SHALL be 1 only in DONE; no pops occur in DRAIN or DONE.
REQ-015 If a FIFO goes empty mid-frame, the block SHALL wait in RUN indefinitely with the counter frozen.

Reset
REQ-016 While reset=0: FSM=IDLE, counter=0, stage valids=0, base_rd_en=img_rd_en=out_wr_en=0, out_din=0, frame_done=0, latched threshold=0, latched mode=0.
REQ-017 Reset asserted mid-frame SHALL discard in-flight beats; the next frame starts at counter 0.

Configuration
REQ-018 With DIFF_MASK_STATS_EN defined, the block SHALL add an output fg_count (32 bits) counting lanes with diff > threshold in the current frame (in both modes).
- fg_count SHALL be valid while frame_done=1 and clear to 0 on the next first pop.
- fg_count resets to 0.
REQ-019 Without DIFF_MASK_STATS_EN, the port and its counter SHALL be absent.

Structure
REQ-020 Package diff_mask_pkg SHALL hold the FSM state enum, the MODE_MASK/MODE_ABS constants and the pixel-width constant 8.
REQ-021 Sub-module diff_lane (one lane: absolute difference and threshold compare) SHALL be instantiated CHANNELS times by generate.

Verification
REQ-022 Mode 0, CHANNELS=1, base=10, img=50, threshold=30 -> out_din=8'hFF two cycles after the pop; img=35 -> 8'h00.
REQ-023 Mode 1, base=200, img=20 -> out_din=180, with no wrap-around.
REQ-024 CHANNELS=4, WIDTH=4, HEIGHT=2, random data -> exactly 2 pushes, lanes correct, frame_done pulses once, then IDLE.
REQ-025 out_full held 1 for 5 cycles with both stages valid -> no pops, out_din stable, no data lost once out_full returns to 0.
REQ-026 img_empty toggles every other cycle -> pops occur only when both FIFOs are non-empty; the output sequence matches the reference model.
REQ-027 Reset pulse after 3 of 8 beats -> outputs go to reset values immediately; the following full frame is processed correctly with DIFF_MASK_STATS_EN fg_count correct.
